// File: rtl/wbc_rr_arbiter.sv
// Round-robin arbiter: NM classic Wishbone masters share one classic slave port.
// A grant is held for a whole CYC. A bus watchdog ends hung cycles with ERR.
//
// Ports
//   i_clk, i_reset_n        bus clock, asynchronous active-low reset
//   i_mcyc/i_mstb/i_mwe     per-master CYC/STB/WE, bit m = master m
//   i_maddr/i_mdata/i_msel  per-master address/write data/byte selects, lane m at [m*W +: W]
//   o_mack/o_merr           per-master ACK/ERR (ERR from slave or watchdog)
//   o_mdata                 slave read data broadcast to every master lane
//   o_s*                    slave-side CYC/STB/WE/ADDR/DATA/SEL
//   i_sack/i_serr/i_sdata   slave ACK/ERR/read data
module wbc_rr_arbiter #(
    parameter int unsigned NM      = 2,
    parameter int unsigned AW      = 30,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NM-1:0]        i_mcyc,
    input  logic [NM-1:0]        i_mstb,
    input  logic [NM-1:0]        i_mwe,
    input  logic [NM*AW-1:0]     i_maddr,
    input  logic [NM*DW-1:0]     i_mdata,
    input  logic [NM*DW/8-1:0]   i_msel,
    output logic [NM-1:0]        o_mack,
    output logic [NM-1:0]        o_merr,
    output logic [NM*DW-1:0]     o_mdata,
    output logic                 o_scyc,
    output logic                 o_sstb,
    output logic                 o_swe,
    output logic [AW-1:0]        o_saddr,
    output logic [DW-1:0]        o_sdata,
    output logic [DW/8-1:0]      o_ssel,
    input  logic                 i_sack,
    input  logic                 i_serr,
    input  logic [DW-1:0]        i_sdata
);

    localparam int unsigned SW  = DW / 8;
    localparam int unsigned GW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [WDW-1:0]  wdog_q, wdog_d;

    logic [NM-1:0]   req;
    logic            found;
    logic [GW-1:0]   winner;
    int unsigned     idx;

    logic            g_cyc, g_stb, g_we;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_data;
    logic [SW-1:0]   g_sel;
    logic            stall;

    assign req = i_mcyc & i_mstb;

    // Granted master's signals
    assign g_cyc  = i_mcyc[grant_q];
    assign g_stb  = i_mstb[grant_q];
    assign g_we   = i_mwe[grant_q];
    assign g_addr = i_maddr[32'(grant_q) * AW +: AW];
    assign g_data = i_mdata[32'(grant_q) * DW +: DW];
    assign g_sel  = i_msel[32'(grant_q) * SW +: SW];

    // Strobe outstanding with no slave response this cycle
    assign stall = g_stb & ~i_sack & ~i_serr;

    // Round-robin scan starting just after the last winner
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        idx    = 0;
        for (int unsigned i = 1; i <= NM; i++) begin
            idx = (32'(last_q) + i) % NM;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NM - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (found) begin
                    grant_d = winner;
                    last_d  = winner;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    wdog_d  = '0;
                end else if (stall && (TIMEOUT != 0)) begin
                    wdog_d = wdog_q + WDW'(1);
                    if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        state_d = ST_ABORT;
                    end
                end else begin
                    wdog_d = '0;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                wdog_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                wdog_d  = '0;
            end
        endcase
    end

    // Outputs: slave bus follows the granted master only while BUSY
    always_comb begin
        o_mack  = '0;
        o_merr  = '0;
        o_mdata = '0;
        o_scyc  = 1'b0;
        o_sstb  = 1'b0;
        o_swe   = 1'b0;
        o_saddr = '0;
        o_sdata = '0;
        o_ssel  = '0;
        case (state_q)
            ST_BUSY: begin
                o_scyc           = g_cyc;
                o_sstb           = g_stb;
                o_swe            = g_we;
                o_saddr          = g_addr;
                o_sdata          = g_data;
                o_ssel           = g_sel;
                o_mack[grant_q]  = i_sack;
                o_merr[grant_q]  = i_serr;
                o_mdata          = {NM{i_sdata}};
            end
            ST_ABORT: begin
                o_merr[grant_q]  = 1'b1;
            end
            default: begin
                o_scyc = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wbc_rr_arbiter.sv
// Directed bench for wbc_rr_arbiter (NM=2, TIMEOUT=8).
module tb_wbc_rr_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NM-1:0]       mcyc, mstb, mwe;
    logic [NM*AW-1:0]    maddr;
    logic [NM*DW-1:0]    mdata;
    logic [NM*SW-1:0]    msel;
    logic [NM-1:0]       mack, merr;
    logic [NM*DW-1:0]    mrdata;
    logic                scyc, sstb, swe;
    logic [AW-1:0]       saddr;
    logic [DW-1:0]       sdata_o;
    logic [SW-1:0]       ssel;
    logic                sack, serr;
    logic [DW-1:0]       sdata_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wbc_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_mcyc    (mcyc),
        .i_mstb    (mstb),
        .i_mwe     (mwe),
        .i_maddr   (maddr),
        .i_mdata   (mdata),
        .i_msel    (msel),
        .o_mack    (mack),
        .o_merr    (merr),
        .o_mdata   (mrdata),
        .o_scyc    (scyc),
        .o_sstb    (sstb),
        .o_swe     (swe),
        .o_saddr   (saddr),
        .o_sdata   (sdata_o),
        .o_ssel    (ssel),
        .i_sack    (sack),
        .i_serr    (serr),
        .i_sdata   (sdata_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        mcyc[m]            = cyc;
        mstb[m]            = stb;
        mwe[m]             = we;
        maddr[m*AW +: AW]  = a;
        mdata[m*DW +: DW]  = d;
        msel[m*SW +: SW]   = s;
    endtask

    task automatic clr_all();
        mcyc = '0; mstb = '0; mwe = '0;
        maddr = '0; mdata = '0; msel = '0;
        sack = 1'b0; serr = 1'b0; sdata_i = '0;
    endtask

    int exp_own[4] = '{0, 1, 0, 1};

    initial begin
        clr_all();

        // 1: reset holds every control output low while inputs toggle
        for (int k = 0; k < 3; k++) begin
            tick();
            mcyc = 2'(k + 1); mstb = 2'b11; mwe = 2'b11;
            maddr = {30'h1234, 30'h5678}; msel = '1;
            sack = k[0]; serr = ~k[0]; sdata_i = 32'hCAFE0000 + 32'(k);
            settle();
            check("rst_ctrl", {scyc, sstb, swe, mack, merr}, 7'd0);
            check("rst_addr", {saddr, mrdata}, 0);
        end
        tick();
        clr_all();
        rst_n = 1'b1;
        set_m(1, 1, 1, 0, 30'h11, 32'h0, 4'hF);
        settle();
        check("m1_req_idle", scyc, 1'b0);
        tick();
        settle();
        check("m1_granted", {scyc, sstb, saddr}, {1'b1, 1'b1, 30'h11});
        sack = 1'b1;
        mcyc[1] = 1'b0; mstb[1] = 1'b0;     // master drops CYC with the ACK
        settle();
        check("m1_ack_drop", mack, 2'b10);
        tick();
        clr_all();

        // 2: two masters re-requesting alternate 0,1,0,1 with idle cycles between
        tick();
        set_m(0, 1, 1, 0, 30'h10, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, 30'h20, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("rr_idle", scyc, 1'b0);
            tick();
            settle();
            check("rr_owner", {scyc, saddr}, {1'b1, (exp_own[k] == 0) ? 30'h10 : 30'h20});
            sack = 1'b1;
            settle();
            check("rr_ack", mack, 64'(1) << exp_own[k]);
            tick();
            sack = 1'b0;
            set_m(exp_own[k], 0, 0, 0, 30'h0, 32'h0, 4'h0);
            settle();
            check("rr_gap", scyc, 1'b0);
            tick();
            if (k < 3)
                set_m(exp_own[k], 1, 1, 0, (exp_own[k] == 0) ? 30'h10 : 30'h20, 32'h0, 4'hF);
        end
        clr_all();
        tick();

        // 3: m0 keeps CYC through a 4-beat burst while m1 waits
        set_m(0, 1, 1, 0, 30'h100, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, 30'h200, 32'h0, 4'hF);
        tick();
        for (int i = 0; i < 4; i++) begin
            maddr[0 +: AW] = 30'h100 + 30'(i);
            mstb[0] = 1'b1;
            sack = 1'b1;
            sdata_i = 32'hA5A50000 + 32'(i);
            settle();
            check("burst_addr", {sstb, saddr}, {1'b1, 30'h100 + 30'(i)});
            check("burst_ack", mack, 2'b01);
            check("burst_rdata", mrdata[31:0], 32'hA5A50000 + 32'(i));
            tick();
            mstb[0] = 1'b0;
            sack = 1'b0;
            settle();
            check("burst_gap", {scyc, sstb, mack}, 4'b1000);
            tick();
        end
        mcyc[0] = 1'b0;
        settle();
        check("burst_end", scyc, 1'b0);
        tick();
        tick();
        settle();
        check("m1_after_burst", {scyc, saddr}, {1'b1, 30'h200});
        sack = 1'b1;
        tick();
        clr_all();
        tick();

        // 4: watchdog aborts an unanswered strobe after 8 cycles
        set_m(1, 1, 1, 0, 30'h33, 32'h0, 4'hF);
        tick();
        for (int k = 0; k < 8; k++) begin
            settle();
            check("wd_wait", {scyc, merr}, 3'b100);
            tick();
        end
        set_m(0, 1, 1, 0, 30'h7, 32'h0, 4'hF);
        sack = 1'b1;
        settle();
        check("wd_abort_bus", {scyc, sstb}, 2'b00);
        check("wd_abort_err", {mack, merr}, 4'b0010);
        tick();
        sack = 1'b0;
        set_m(1, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        settle();
        check("wd_post_idle", {scyc, merr}, 3'b000);
        tick();
        settle();
        check("wd_next_grant", {scyc, saddr}, {1'b1, 30'h7});
        sack = 1'b1;
        tick();
        clr_all();
        tick();

        // 5: m1 write terminated by slave ERR
        set_m(1, 1, 1, 1, 30'h3, 32'hDEADBEEF, 4'b0011);
        set_m(0, 1, 1, 0, 30'h5, 32'h0, 4'hF);
        tick();
        serr = 1'b1;
        settle();
        check("wr_bus", {swe, ssel, saddr}, {1'b1, 4'b0011, 30'h3});
        check("wr_data", sdata_o, 32'hDEADBEEF);
        check("wr_err", {merr, mack}, 4'b1000);
        tick();
        serr = 1'b0;
        set_m(1, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        tick();
        tick();

        // 6: asynchronous reset mid-strobe, arbitration restarts from last=NM-1
        settle();
        check("pre_rst_busy", {scyc, saddr}, {1'b1, 30'h5});
        sack = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", {scyc, sstb, mack, merr}, 6'd0);
        tick();
        clr_all();
        rst_n = 1'b1;
        set_m(0, 1, 1, 0, 30'h40, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, 30'h50, 32'h0, 4'hF);
        tick();
        settle();
        check("post_rst_tie", saddr, 30'h40);
        sack = 1'b1;
        serr = 1'b1;
        settle();
        check("ack_and_err", {mack, merr}, 4'b0101);
        tick();
        clr_all();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
